// File: rtl/dmem_responder_if.sv
// Load/store bus between the MA stage (master) and the data memory
// responder (slave).
//
// Handshake: the master raises memR or memW with mem_ctrl/addr/dataW and
// must hold all of them stable while stall=1. The cycle after stall falls
// is the completion cycle: done=1 for exactly one cycle, with dataR and err
// valid. The master advances at the end of that cycle.
//
// Signals:
//   memR, memW  load / store request
//   mem_ctrl    RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   addr        byte address
//   dataW       right-aligned store data
//   dataR       extended load result (valid with done)
//   stall       hold the pipeline
//   done        one-cycle completion pulse
//   err         access fault, valid with done
interface dmem_responder_if;
  logic        memR;
  logic        memW;
  logic [2:0]  mem_ctrl;
  logic [31:0] addr;
  logic [31:0] dataW;
  logic [31:0] dataR;
  logic        stall;
  logic        done;
  logic        err;

  modport master (
    output memR, memW, mem_ctrl, addr, dataW,
    input  dataR, stall, done, err
  );

  modport slave (
    input  memR, memW, mem_ctrl, addr, dataW,
    output dataR, stall, done, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Memory-side responder for the MA stage. Services byte/half/word loads and
// stores from an internal word-organised RAM after LATENCY cycles, with lane
// steering, sign/zero extension and alignment/range/encoding checks.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   bus          dmem_responder_if slave modport (request in, result out)
//   o_dbg_state  current FSM state (0 IDLE, 1 WAIT, 2 DONE)
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  dmem_responder_if.slave    bus,
  output logic [1:0]         o_dbg_state
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic        w_stall;

  // Captured request
  logic        r_rd;
  logic        r_wr;
  logic [2:0]  r_ctrl;
  logic [31:0] r_addr;
  logic [31:0] r_dataW;

  // Registered results
  logic [31:0] r_dataR;
  logic        r_done;
  logic        r_err;

  logic [31:0] r_mem [DEPTH];

  // In IDLE the live bus is the request being decided on (this matters when
  // LATENCY==1 and the commit happens on the capture edge); afterwards the
  // captured copy is authoritative so input changes during WAIT are ignored.
  logic        w_live;
  logic        w_rd;
  logic        w_wr;
  logic [2:0]  w_ctrl;
  logic [31:0] w_addr;
  logic [31:0] w_dataW;

  assign w_live  = (r_state == IDLE);
  assign w_rd    = w_live ? bus.memR     : r_rd;
  assign w_wr    = w_live ? bus.memW     : r_wr;
  assign w_ctrl  = w_live ? bus.mem_ctrl : r_ctrl;
  assign w_addr  = w_live ? bus.addr     : r_addr;
  assign w_dataW = w_live ? bus.dataW    : r_dataW;

  // Address decode and fault detection
  logic [AW-1:0] w_idx;
  logic          w_oor;
  logic          w_is_half;
  logic          w_is_word;
  logic          w_bad_ctrl;
  logic          w_misalign;
  logic          w_err;

  assign w_idx      = w_addr[AW+1:2];
  assign w_oor      = (32'(w_idx) >= 32'(DEPTH)) || ((w_addr >> (AW + 2)) != 32'd0);
  assign w_is_half  = (w_ctrl[1:0] == 2'b01);
  assign w_is_word  = (w_ctrl[1:0] == 2'b10);
  assign w_bad_ctrl = (w_ctrl == 3'b011) || (w_ctrl == 3'b110) || (w_ctrl == 3'b111) ||
                      (w_wr && w_ctrl[2]);
  assign w_misalign = (w_is_half && w_addr[0]) || (w_is_word && (w_addr[1:0] != 2'b00));
  assign w_err      = w_oor || w_bad_ctrl || w_misalign || (w_rd && w_wr);

  // FSM next state / outputs
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_stall    = 1'b0;
    case (r_state)
      IDLE: begin
        w_stall = bus.memR | bus.memW;
        if (bus.memR | bus.memW) begin
          w_cnt_next = CNT_INIT;
          w_next     = (LATENCY == 1) ? DONE : WAIT;
        end
      end
      WAIT: begin
        w_stall    = 1'b1;
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // DONE is only ever entered from IDLE or WAIT, so this is the commit edge.
  logic w_commit;
  assign w_commit = (w_next == DONE);

  // Load extraction from the addressed word
  logic [31:0] w_word;
  logic [31:0] w_bsh;
  logic [31:0] w_hsh;
  logic [31:0] w_load;

  assign w_word = r_mem[w_idx];
  assign w_bsh  = w_word >> {w_addr[1:0], 3'b000};
  assign w_hsh  = w_word >> {w_addr[1], 4'b0000};

  always_comb begin
    w_load = 32'd0;
    case (w_ctrl)
      3'b000:  w_load = {{24{w_bsh[7]}}, w_bsh[7:0]};
      3'b001:  w_load = {{16{w_hsh[15]}}, w_hsh[15:0]};
      3'b010:  w_load = w_word;
      3'b100:  w_load = {24'd0, w_bsh[7:0]};
      3'b101:  w_load = {16'd0, w_hsh[15:0]};
      default: w_load = 32'd0;
    endcase
  end

  // Store lane steering: replicate data across lanes, enable only the target
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = w_dataW;
    case (w_ctrl[1:0])
      2'b00: begin
        w_be    = 4'b0001 << w_addr[1:0];
        w_wdata = {4{w_dataW[7:0]}};
      end
      2'b01: begin
        w_be    = w_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{w_dataW[15:0]}};
      end
      2'b10: begin
        w_be    = 4'b1111;
        w_wdata = w_dataW;
      end
      default: begin
        w_be    = 4'b0000;
        w_wdata = w_dataW;
      end
    endcase
  end

  // State, capture and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_ctrl  <= 3'd0;
      r_addr  <= 32'd0;
      r_dataW <= 32'd0;
      r_dataR <= 32'd0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_live && (bus.memR | bus.memW)) begin
        r_rd    <= bus.memR;
        r_wr    <= bus.memW;
        r_ctrl  <= bus.mem_ctrl;
        r_addr  <= bus.addr;
        r_dataW <= bus.dataW;
      end
      r_done <= w_commit;
      r_err  <= w_commit && w_err;
      if (w_commit) begin
        r_dataR <= w_err ? 32'd0 : w_load;
      end
    end
  end

  // RAM has no reset; rst_n gating keeps an access aborted by reset from
  // writing on a clock edge that occurs while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && w_commit && w_wr && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.stall   = w_stall & rst_n;
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign bus.dataR   = r_dataR;
  assign o_dbg_state = r_state;

endmodule
